// File: rtl/cntchk_pkg.sv
// Shared types and widths for the count-bus checker.
package cntchk_pkg;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned ERR_W = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAcquire = 2'd1,
        StLocking = 2'd2,
        StLocked  = 2'd3
    } state_t;

endpackage

// File: rtl/cntchk_sync_filter.sv
// Synchronizes the raw count bus and sample enable, then tracks how long the synchronized
// word has been stable; stable_hit marks the single cycle a word becomes eligible.
module cntchk_sync_filter
    import cntchk_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] bus_in,
    input  logic             sample_en,
    output logic [CNT_W-1:0] candidate,
    output logic             stable_hit,
    output logic             en_sync
);

    localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);
    localparam logic [3:0] STABLE_PRE = 4'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0]       bus_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] en_pipe;
    logic [3:0]             stable_cnt;
    logic [CNT_W-1:0]       sync_word;

    assign sync_word = bus_sync[SYNC_STAGES-1];
    assign en_sync   = en_pipe[SYNC_STAGES-1];

    // Skewed intermediate values reload the candidate and restart the count.
    assign stable_hit = (sync_word == candidate) && (stable_cnt == STABLE_PRE);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                bus_sync[i] <= '0;
            end
            en_pipe    <= '0;
            candidate  <= '0;
            stable_cnt <= '0;
        end else begin
            bus_sync[0] <= bus_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                bus_sync[i] <= bus_sync[i-1];
            end
            en_pipe <= {en_pipe[SYNC_STAGES-2:0], sample_en};
            if (sync_word != candidate) begin
                candidate  <= sync_word;
                stable_cnt <= '0;
            end else if (stable_cnt != STABLE_MAX) begin
                stable_cnt <= stable_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/count_bus_checker.sv
// Checks that a free-running 16-bit count bus steps by +1, tracking lock and error count.
// Optional CNTCHK_ERR_CAPTURE_EN adds sticky capture of the first locked-state error.
module count_bus_checker
    import cntchk_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned LOCK_COUNT    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] bus_in,
    input  logic             sample_en,
    output logic [CNT_W-1:0] accepted_o,
    output logic             valid_o,
    output logic             locked_o,
    output logic             err_pulse_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic [1:0]       state_o
`ifdef CNTCHK_ERR_CAPTURE_EN
    ,
    output logic [CNT_W-1:0] err_exp_o,
    output logic [CNT_W-1:0] err_got_o
`endif
);

    localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);

    state_t           state;
    logic [7:0]       step_cnt;
    logic [CNT_W-1:0] candidate;
    logic [CNT_W-1:0] next_exp;
    logic             stable_hit;
    logic             en_sync;
    logic             accept;
    logic             good_step;

    cntchk_sync_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_sync_filter (
        .clk       (clk),
        .rst       (rst),
        .bus_in    (bus_in),
        .sample_en (sample_en),
        .candidate (candidate),
        .stable_hit(stable_hit),
        .en_sync   (en_sync)
    );

    assign next_exp  = accepted_o + CNT_W'(1);
    assign good_step = (candidate == next_exp);

    // An unchanged word is only taken while acquiring the reference.
    assign accept = stable_hit && en_sync && (state != StIdle) &&
                    ((candidate != accepted_o) || (state == StAcquire));

    assign state_o  = state;
    assign locked_o = (state == StLocked);

`ifdef CNTCHK_ERR_CAPTURE_EN
    logic err_captured;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            step_cnt    <= '0;
            accepted_o  <= '0;
            valid_o     <= 1'b0;
            err_pulse_o <= 1'b0;
            err_cnt_o   <= '0;
`ifdef CNTCHK_ERR_CAPTURE_EN
            err_captured <= 1'b0;
            err_exp_o    <= '0;
            err_got_o    <= '0;
`endif
        end else begin
            valid_o     <= accept;
            err_pulse_o <= 1'b0;
            if (accept) begin
                accepted_o <= candidate;
            end
            if (!en_sync) begin
                state <= StIdle;
            end else begin
                case (state)
                    StIdle: state <= StAcquire;
                    StAcquire: begin
                        if (accept) begin
                            state    <= StLocking;
                            step_cnt <= '0;
                        end
                    end
                    StLocking: begin
                        if (accept) begin
                            if (good_step) begin
                                step_cnt <= step_cnt + 8'd1;
                                if (step_cnt == LOCK_LAST) begin
                                    state <= StLocked;
                                end
                            end else begin
                                step_cnt <= '0;
                            end
                        end
                    end
                    StLocked: begin
                        if (accept && !good_step) begin
                            err_pulse_o <= 1'b1;
                            if (err_cnt_o != {ERR_W{1'b1}}) begin
                                err_cnt_o <= err_cnt_o + ERR_W'(1);
                            end
                            state    <= StLocking;
                            step_cnt <= '0;
`ifdef CNTCHK_ERR_CAPTURE_EN
                            if (!err_captured) begin
                                err_captured <= 1'b1;
                                err_exp_o    <= next_exp;
                                err_got_o    <= candidate;
                            end
`endif
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule
